// File: rtl/ntt_pkg.sv
// ntt_pkg: shared definitions for the NTT stage sequencer and future address
// generators.
//   - ntt_state_e      : sequencer FSM state encoding
//   - DefaultLogN      : default log2 of the transform size
//   - DefaultPipeLat   : default butterfly datapath latency (read to write port)
//   - ntt_insert_zero  : inserts a 0 bit into a value at a given bit position
package ntt_pkg;

    localparam int unsigned DefaultLogN    = 8;
    localparam int unsigned DefaultPipeLat = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } ntt_state_e;

    // Bits [pos-1:0] stay in place, bits above move up by one, bit 'pos' becomes 0.
    function automatic logic [31:0] ntt_insert_zero(input logic [31:0]   val,
                                                    input int unsigned  pos);
        logic [31:0] low_mask;
        low_mask = (32'd1 << pos) - 32'd1;
        return ((val & ~low_mask) << 1) | (val & low_mask);
    endfunction

endpackage

// File: rtl/ntt_addr_delay.sv
// ntt_addr_delay: shift-register delay line that aligns the issue strobe and
// read addresses with the datapath output.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears every stage
//   d_i    : input word {strobe, addresses}
//   q_o    : d_i delayed by Depth cycles
module ntt_addr_delay #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] pipe_q [Depth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < Depth; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl: sequencer for the dual-butterfly NTT datapath. On start it walks
// all LOG_N stages of an in-place radix-2 transform, issuing two butterflies per
// cycle (N/4 issue cycles per stage), then drains PIPE_LAT cycles so the next
// stage never reads a coefficient before it has been written back.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start                 : begin a transform (ignored unless idle)
//   inverse               : Gentleman-Sande ordering, sampled with start
//                           (present only when NTT_CTRL_INTT_EN is defined)
//   busy, done            : transform in progress / one-cycle completion pulse
//   stage                 : current stage index
//   rd_en, rd_addr_*      : issue strobe and coefficient read addresses
//   tw_addr0, tw_addr1    : twiddle ROM indices for butterfly 0 / 1
//   wr_en, wr_addr_*      : issue strobe and addresses delayed by PIPE_LAT
//
// Build option: define NTT_CTRL_INTT_EN to add the inverse ordering.
module ntt_stage_ctrl
    import ntt_pkg::*;
#(
    parameter int unsigned LOG_N    = DefaultLogN,
    parameter int unsigned PIPE_LAT = DefaultPipeLat
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
`ifdef NTT_CTRL_INTT_EN
    input  logic                       inverse,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(LOG_N)-1:0]   stage,
    output logic                       rd_en,
    output logic [LOG_N-1:0]           rd_addr_a0,
    output logic [LOG_N-1:0]           rd_addr_b0,
    output logic [LOG_N-1:0]           rd_addr_a1,
    output logic [LOG_N-1:0]           rd_addr_b1,
    output logic [LOG_N-2:0]           tw_addr0,
    output logic [LOG_N-2:0]           tw_addr1,
    output logic                       wr_en,
    output logic [LOG_N-1:0]           wr_addr_a0,
    output logic [LOG_N-1:0]           wr_addr_b0,
    output logic [LOG_N-1:0]           wr_addr_a1,
    output logic [LOG_N-1:0]           wr_addr_b1
);

    localparam int unsigned N  = 1 << LOG_N;
    localparam int unsigned SW = $clog2(LOG_N);
    localparam int unsigned CW = (LOG_N > 2) ? LOG_N - 2 : 1;
    localparam int unsigned DW = 4 * LOG_N + 1;

    localparam logic [CW-1:0] CLast = CW'(N / 4 - 1);
    localparam logic [3:0]    DLast = 4'(PIPE_LAT - 1);
    localparam logic [SW-1:0] SLast = SW'(LOG_N - 1);

    ntt_state_e    state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [CW-1:0] c_q, c_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic          inv_sel;

`ifdef NTT_CTRL_INTT_EN
    logic          inv_q, inv_d;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        c_d     = c_q;
        dcnt_d  = dcnt_q;
`ifdef NTT_CTRL_INTT_EN
        inv_d   = inv_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    stage_d = '0;
                    c_d     = '0;
`ifdef NTT_CTRL_INTT_EN
                    inv_d   = inverse;
`endif
                end
            end
            StIssue: begin
                if (c_q == CLast) begin
                    state_d = StDrain;
                    dcnt_d  = '0;
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            StDrain: begin
                if (dcnt_q == DLast) begin
                    if (stage_q < SLast) begin
                        state_d = StIssue;
                        stage_d = stage_q + SW'(1);
                        c_d     = '0;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef NTT_CTRL_INTT_EN
    assign inv_sel = inv_d;
`else
    assign inv_sel = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Address generation, computed from next state so the outputs are registered
    // ------------------------------------------------------------------
    logic                 issue_d;
    logic [LOG_N-1:0]     a0_d, b0_d, a1_d, b1_d;
    logic [LOG_N-2:0]     tw0_d, tw1_d;
    int unsigned          stg, log2h, tw_sh, k0, k1, mask, a0_full, a1_full;

    always_comb begin
        issue_d = (state_d == StIssue);
        stg     = 32'(stage_d);
        // Forward: h shrinks from N/2; inverse: h grows from 1.
        log2h   = inv_sel ? stg : (LOG_N - 1 - stg);
        tw_sh   = inv_sel ? (LOG_N - 1 - stg) : stg;
        k0      = 32'(c_d) << 1;
        k1      = k0 | 32'd1;
        mask    = (32'd1 << log2h) - 32'd1;
        a0_full = ntt_insert_zero(k0, log2h);
        a1_full = ntt_insert_zero(k1, log2h);
        a0_d    = '0;
        b0_d    = '0;
        a1_d    = '0;
        b1_d    = '0;
        tw0_d   = '0;
        tw1_d   = '0;
        if (issue_d) begin
            a0_d  = LOG_N'(a0_full);
            b0_d  = LOG_N'(a0_full | (32'd1 << log2h));
            a1_d  = LOG_N'(a1_full);
            b1_d  = LOG_N'(a1_full | (32'd1 << log2h));
            tw0_d = (LOG_N-1)'((k0 & mask) << tw_sh);
            tw1_d = (LOG_N-1)'((k1 & mask) << tw_sh);
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    logic             busy_q, done_q, rd_en_q;
    logic [LOG_N-1:0] a0_q, b0_q, a1_q, b1_q;
    logic [LOG_N-2:0] tw0_q, tw1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            stage_q <= '0;
            c_q     <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            a0_q    <= '0;
            b0_q    <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            tw0_q   <= '0;
            tw1_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            c_q     <= c_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= (state_d == StIssue) || (state_d == StDrain);
            done_q  <= (state_d == StDone);
            rd_en_q <= issue_d;
            a0_q    <= a0_d;
            b0_q    <= b0_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            tw0_q   <= tw0_d;
            tw1_q   <= tw1_d;
        end
    end

`ifdef NTT_CTRL_INTT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign stage      = stage_q;
    assign rd_en      = rd_en_q;
    assign rd_addr_a0 = a0_q;
    assign rd_addr_b0 = b0_q;
    assign rd_addr_a1 = a1_q;
    assign rd_addr_b1 = b1_q;
    assign tw_addr0   = tw0_q;
    assign tw_addr1   = tw1_q;

    // ------------------------------------------------------------------
    // Write-back alignment
    // ------------------------------------------------------------------
    logic [DW-1:0] dly_in, dly_out;

    assign dly_in = {rd_en_q, a0_q, b0_q, a1_q, b1_q};

    ntt_addr_delay #(
        .Depth (PIPE_LAT),
        .Width (DW)
    ) u_addr_delay (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (dly_in),
        .q_o   (dly_out)
    );

    assign {wr_en, wr_addr_a0, wr_addr_b0, wr_addr_a1, wr_addr_b1} = dly_out;

endmodule

// File: doc/ntt_stage_ctrl.md
# ntt_stage_ctrl

Sequencer for the NTT butterfly datapath, built around the dual multiplier/modulo unit (two products per cycle). Once started, it steps through all LOG_N stages of an in-place radix-2 transform. Each cycle it issues two butterflies: coefficient read addresses and twiddle addresses. Write-back addresses and enables are delayed to line up with the datapath output. Between stages it drains the pipeline so that no stage reads a coefficient before the previous stage has written it.

## Interface
- LOG_N, 8: log2 of transform size N; legal range 2..12.
- PIPE_LAT, 4: cycles from rd_en to valid butterfly results at the memory write port; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a transform; honoured only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the end of the last DRAIN.
- done  out  1  one-cycle pulse in the cycle after the last DRAIN.
- stage  out  $clog2(LOG_N)  index of the current stage, 0-based.
- rd_en  out  1  read/issue strobe for both butterflies.
- rd_addr_a0, rd_addr_b0, rd_addr_a1, rd_addr_b1  out  LOG_N each  upper/lower coefficient addresses for butterfly 0 and butterfly 1.
- tw_addr0, tw_addr1  out  LOG_N-1 each  twiddle ROM indices (weight_1 and weight_2 paths).
- wr_en  out  1  rd_en delayed by PIPE_LAT.
- wr_addr_a0, wr_addr_b0, wr_addr_a1, wr_addr_b1  out  LOG_N each  the rd addresses delayed by PIPE_LAT.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - start=1 → ISSUE; stage and cycle counter c are cleared.
- **ISSUE**
  - rd_en=1 every cycle; c runs 0..N/4-1.
  - After the last issue → DRAIN.
- **DRAIN**
  - rd_en=0 for exactly PIPE_LAT cycles.
  - Then, if stage<LOG_N-1: stage+1, c=0, return to ISSUE; otherwise go to DONE.
- **DONE**
  - done=1 for one cycle, then IDLE.
- Forward (Cooley-Tukey) address generation:
  - Butterfly indices: k0=2c, k1=2c+1.
  - Half-size: h=N>>(stage+1).
  - o=k mod h; a = (k/h)·2h + o, i.e. k with a 0 bit inserted at bit position log2 h.
  - b=a+h; tw=o<<stage.
- All address arithmetic is unsigned and truncated to its port width; no wrap can occur within legal parameters.
- Delay line: rd_en and the four rd addresses shift through a PIPE_LAT-deep register chain to wr_en/wr_addr_*.
  - The chain's valid bits are cleared by rst.
- start in ISSUE, DRAIN or DONE is ignored and not queued.
- rst mid-transform:
  - State goes to IDLE immediately and all outputs go to their reset values.
  - In-flight writes are discarded (wr_en=0); memory contents are undefined.

## Timing
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, stage=0, all addresses and tw indices 0.
- start sampled at edge T → first rd_en at T+1.
- Each stage takes N/4 issue cycles plus PIPE_LAT drain cycles.
- Total busy cycles: LOG_N·(N/4+PIPE_LAT). done follows the last busy cycle.
- The write of a stage's final butterfly and the first read of the next stage are never in the same cycle. The read occurs one cycle later, which suits synchronous-write RAM.
- Outputs are registered; addresses are valid in the same cycle as their strobe.

## Configuration
- NTT_CTRL_INTT_EN defined:
  - Adds an input port `inverse` (1 bit), sampled with start and held for the whole transform.
  - inverse=1 selects the Gentleman-Sande ordering: h=1<<stage (h grows), tw=o<<(LOG_N-1-stage).
  - Latency is identical to the forward transform.
- NTT_CTRL_INTT_EN undefined:
  - The `inverse` port is absent and only the forward ordering exists.

## Structure
- Shared package ntt_pkg:
  - FSM state enum.
  - Default LOG_N and PIPE_LAT constants.
  - A function that inserts a zero bit at a given position (shared with future address generators).
- Sub-module ntt_addr_delay: a parameterised shift-register delay line (depth PIPE_LAT, data width 4·LOG_N+1).

## Test plan
- **Reset values:** LOG_N=3, PIPE_LAT=4; reset, then start at T.
  - Stage 0: (a0,b0,a1,b1,tw0,tw1) = (0,4,1,5,0,1) at T+1 and (2,6,3,7,2,3) at T+2.
  - wr_en high at T+5 and T+6.
  - busy is high for 18 cycles; done pulses at T+19.
- **Later stages (same run):**
  - Stage 1 issue is (0,2,1,3,0,2) then (4,6,5,7,0,2).
  - Stage 2 issue is (0,1,2,3,0,0) then (4,5,6,7,0,0).
  - No cycle has rd_en and a wr_en of the previous stage targeting the same address.
- **start while busy:** pulse start mid-ISSUE and again in DONE → no restart; exactly one done pulse.
- **Reset mid-operation:** rst asserted during stage 1 DRAIN → all outputs are 0 asynchronously and wr_en stays 0 after release. A new start then runs the full 18-cycle transform from stage 0.
- **Inverse mode (NTT_CTRL_INTT_EN, inverse=1, LOG_N=3):**
  - Stage 0 issue is (0,1,2,3,0,0) then (4,5,6,7,0,0).
  - Stage 2 issue is (0,4,1,5,0,1) then (2,6,3,7,2,3).
- **Parameter sweep:** LOG_N=8, PIPE_LAT=1 → busy for 8·65=520 cycles. Every address pair in every stage is covered exactly once, checked against a scoreboard.
